// File: rtl/pkg_tpu.sv
// Shared TPU types and sizing for the data-memory bank.
//   DMEM_DEPTH  : words in the data array (power of two)
//   RDBUF_DEPTH : entries in the read-return buffer (power of two)
//   address_t   : AGU address; only the low IDX_W bits index the array
//   data_t      : memory word
package pkg_tpu;
    localparam int DMEM_DEPTH  = 256;
    localparam int RDBUF_DEPTH = 4;
    localparam int ADDR_W      = 16;
    localparam int DATA_W      = 32;
    localparam int IDX_W       = $clog2(DMEM_DEPTH);
    localparam int CRED_W      = $clog2(RDBUF_DEPTH + 1);

    typedef logic [ADDR_W-1:0] address_t;
    typedef logic [DATA_W-1:0] data_t;
endpackage

// File: rtl/dmem_rdbuf.sv
// Read-return FIFO, RDBUF_DEPTH entries of data_t, in-order.
//   push/wr_data : enqueue one word
//   pop          : dequeue head (rd_data is the head, valid when !empty)
//   empty/full   : occupancy flags
// Overflow/underflow cannot happen when the caller respects credits;
// the assertions catch it if that contract is ever broken.
module dmem_rdbuf
    import pkg_tpu::*;
(
    input  logic  clock,
    input  logic  reset,
    input  logic  push,
    input  data_t wr_data,
    input  logic  pop,
    output data_t rd_data,
    output logic  empty,
    output logic  full
);
    localparam int PTR_W = $clog2(RDBUF_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    data_t            mem [RDBUF_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(RDBUF_DEPTH));
    assign rd_data = mem[rd_ptr];

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

    a_no_overflow:  assert property (@(posedge clock) disable iff (reset) !(push && full));
    a_no_underflow: assert property (@(posedge clock) disable iff (reset) !(pop && empty));
endmodule

// File: rtl/dmem_bank.sv
// Single-port data memory bank shared by a load AGU and a store AGU.
//   clock/reset           : rising-edge clock, synchronous active-high reset
//   I_Ld_Req/I_Ld_Addr    : load request (pre-masked by O_Ld_Stall)
//   O_Ld_Stall            : load stall (store priority, no credits, init)
//   O_Ld_Data/O_Ld_Valid  : head of the read-return buffer
//   I_Ld_Ready            : consumer accepts O_Ld_Data
//   I_St_Req/Addr/Data    : store request (pre-masked by O_St_Stall)
//   O_St_Stall            : registered store stall (only during init)
//   O_Busy                : reads outstanding or buffered
// Load path: array read at end of accept cycle T, buffer push at end of
// T+1, data visible from T+2. Credits bound reads in flight plus buffered
// entries to RDBUF_DEPTH, so the buffer can never overflow.
module dmem_bank
    import pkg_tpu::*;
(
    input  logic     clock,
    input  logic     reset,
    input  logic     I_Ld_Req,
    input  address_t I_Ld_Addr,
    output logic     O_Ld_Stall,
    output data_t    O_Ld_Data,
    output logic     O_Ld_Valid,
    input  logic     I_Ld_Ready,
    input  logic     I_St_Req,
    input  address_t I_St_Addr,
    input  data_t    I_St_Data,
    output logic     O_St_Stall,
    output logic     O_Busy
);
    data_t             mem [DMEM_DEPTH];
    logic              r_init;
    logic [CRED_W-1:0] r_credits;
    data_t             rd_data;
    logic              rd_vld;
    logic              ld_acc;
    logic              st_acc;
    logic              pop;
    logic              empty;
    logic              full;
    logic [IDX_W-1:0]  ld_idx;
    logic [IDX_W-1:0]  st_idx;

    // Upper address bits are intentionally ignored (wrap-around indexing).
    logic unused_addr_bits;
    assign unused_addr_bits = &{1'b0, I_Ld_Addr[ADDR_W-1:IDX_W], I_St_Addr[ADDR_W-1:IDX_W]};

    assign ld_idx = I_Ld_Addr[IDX_W-1:0];
    assign st_idx = I_St_Addr[IDX_W-1:0];

    // Store stall comes straight from a flop so the AGUs never see a
    // combinational path from their own requests.
    assign O_St_Stall = r_init;
    assign O_Ld_Stall = I_St_Req | (r_credits == '0) | r_init;

    // Gating with the stall makes an illegal coincident load harmless:
    // the store wins and the load neither reads nor spends a credit.
    assign st_acc = I_St_Req & ~r_init;
    assign ld_acc = I_Ld_Req & ~O_Ld_Stall;

    assign O_Ld_Valid = ~empty;
    assign pop        = O_Ld_Valid & I_Ld_Ready;
    assign O_Busy     = (r_credits != CRED_W'(RDBUF_DEPTH));

    always_ff @(posedge clock) begin
        if (reset) begin
            r_init    <= 1'b1;
            r_credits <= CRED_W'(RDBUF_DEPTH);
            rd_vld    <= 1'b0;
        end else begin
            r_init <= 1'b0;
            rd_vld <= ld_acc;
            case ({ld_acc, pop})
                2'b10:   r_credits <= r_credits - 1'b1;
                2'b01:   r_credits <= r_credits + 1'b1;
                default: r_credits <= r_credits;
            endcase
        end
    end

    // Array is not reset; contents survive a mid-operation reset. A store
    // at T lands before a load at T+1 reads, so RAW needs no bypass.
    always_ff @(posedge clock) begin
        if (st_acc) mem[st_idx] <= I_St_Data;
        if (ld_acc) rd_data     <= mem[ld_idx];
    end

    dmem_rdbuf u_rdbuf (
        .clock   (clock),
        .reset   (reset),
        .push    (rd_vld),
        .wr_data (rd_data),
        .pop     (pop),
        .rd_data (O_Ld_Data),
        .empty   (empty),
        .full    (full)
    );

    a_credit_range: assert property (@(posedge clock) disable iff (reset)
                                     r_credits <= CRED_W'(RDBUF_DEPTH));
endmodule

// File: tb/tb_dmem_bank.sv
module tb_dmem_bank;
    import pkg_tpu::*;

    logic     clock = 1'b0;
    logic     reset = 1'b1;
    logic     ld_req = 1'b0;
    address_t ld_addr = '0;
    logic     ld_stall;
    data_t    ld_data;
    logic     ld_valid;
    logic     ld_ready = 1'b0;
    logic     st_req = 1'b0;
    address_t st_addr = '0;
    data_t    st_data = '0;
    logic     st_stall;
    logic     busy;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    dmem_bank dut (
        .clock      (clock),
        .reset      (reset),
        .I_Ld_Req   (ld_req),
        .I_Ld_Addr  (ld_addr),
        .O_Ld_Stall (ld_stall),
        .O_Ld_Data  (ld_data),
        .O_Ld_Valid (ld_valid),
        .I_Ld_Ready (ld_ready),
        .I_St_Req   (st_req),
        .I_St_Addr  (st_addr),
        .I_St_Data  (st_data),
        .O_St_Stall (st_stall),
        .O_Busy     (busy)
    );

    typedef struct {
        bit          lr;
        logic [15:0] la;
        bit          sr;
        logic [15:0] sa;
        logic [31:0] sd;
        bit          rdy;
        bit          e_lst;
        bit          e_sst;
        bit          e_vld;
        logic [31:0] e_dat;
        bit          e_busy;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit lr, logic [15:0] la, bit sr, logic [15:0] sa,
                                logic [31:0] sd, bit rdy, bit lst, bit sst,
                                bit vld, logic [31:0] dat, bit bsy);
        vec_t v;
        v.lr = lr; v.la = la; v.sr = sr; v.sa = sa; v.sd = sd; v.rdy = rdy;
        v.e_lst = lst; v.e_sst = sst; v.e_vld = vld; v.e_dat = dat; v.e_busy = bsy;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic drive(bit lr, logic [15:0] la, bit sr, logic [15:0] sa,
                         logic [31:0] sd, bit rdy);
        ld_req = lr; ld_addr = la; st_req = sr; st_addr = sa; st_data = sd;
        ld_ready = rdy;
    endtask

    task automatic idle(bit rdy);
        drive(0, 16'h0, 0, 16'h0, 32'h0, rdy);
    endtask

    logic [31:0] got[$];
    logic [31:0] exp_q[$];

    initial begin
        // ---- reset and release ----
        idle(1'b0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_ld_stall", ld_stall, 1);
        chk("rst_st_stall", st_stall, 1);
        chk("rst_valid", ld_valid, 0);
        chk("rst_busy", busy, 0);
        @(posedge clock); #1; reset = 1'b0;
        @(negedge clock);
        chk("rel_ld_stall", ld_stall, 1);
        chk("rel_st_stall", st_stall, 1);
        chk("rel_valid", ld_valid, 0);
        chk("rel_busy", busy, 0);

        // ---- table-driven vectors ----
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        for (int i = 0; i < 8; i++)
            vecs.push_back(mk(0, 0, 1, 16'(i), 32'h10 + i, 1, 1, 0, 0, 0, 0));
        for (int i = 0; i < 8; i++)
            vecs.push_back(mk(1, 16'(i), 0, 0, 0, 1, 0, 0, i >= 2,
                              (i >= 2) ? 32'h10 + i - 2 : 32'h0, i >= 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 1, 32'h16, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 1, 32'h17, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        // wrap-around store then load (also store-then-load RAW)
        vecs.push_back(mk(0, 0, 1, 16'h105, 32'hAA, 1, 1, 0, 0, 0, 0));
        vecs.push_back(mk(1, 16'h005, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 1, 32'hAA, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        // back-pressure: Ready low, 4 loads fill credits, then drain
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(1, 2, 0, 0, 0, 0, 0, 0, 1, 32'h10, 1));
        vecs.push_back(mk(1, 3, 0, 0, 0, 0, 0, 0, 1, 32'h10, 1));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 32'h10, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 1, 32'h10, 1));
        vecs.push_back(mk(1, 4, 0, 0, 0, 1, 0, 0, 1, 32'h11, 1));
        vecs.push_back(mk(1, 6, 0, 0, 0, 1, 0, 0, 1, 32'h12, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 1, 32'h13, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 1, 32'h14, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 1, 32'h16, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clock); #1;
            drive(vecs[i].lr, vecs[i].la, vecs[i].sr, vecs[i].sa, vecs[i].sd, vecs[i].rdy);
            @(negedge clock);
            chk($sformatf("v%0d_ld_stall", i), ld_stall, vecs[i].e_lst);
            chk($sformatf("v%0d_st_stall", i), st_stall, vecs[i].e_sst);
            chk($sformatf("v%0d_valid", i), ld_valid, vecs[i].e_vld);
            chk($sformatf("v%0d_busy", i), busy, vecs[i].e_busy);
            if (vecs[i].e_vld) chk($sformatf("v%0d_data", i), ld_data, vecs[i].e_dat);
        end

        // ---- store request in the middle of a load stream ----
        // cycle 2 also carries an illegal coincident load to index 7: dropped
        got.delete();
        for (int c = 0; c < 16; c++) begin
            @(posedge clock); #1;
            case (c)
                0: drive(1, 16'h0, 0, 16'h0, 32'h0, 1);
                1: drive(1, 16'h1, 0, 16'h0, 32'h0, 1);
                2: drive(1, 16'h7, 1, 16'h20, 32'h55, 1);
                3: drive(1, 16'h2, 0, 16'h0, 32'h0, 1);
                4: drive(1, 16'h20, 0, 16'h0, 32'h0, 1);
                default: idle(1'b1);
            endcase
            @(negedge clock);
            if (c == 2) chk("mix_store_ld_stall", ld_stall, 1);
            if (c == 2) chk("mix_store_st_stall", st_stall, 0);
            if (c == 3) chk("mix_after_ld_stall", ld_stall, 0);
            if (ld_valid) got.push_back(ld_data);
        end
        exp_q = '{32'h10, 32'h11, 32'h12, 32'h55};
        chk("mix_count", got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            chk($sformatf("mix_data%0d", i), (i < got.size()) ? got[i] : 32'hDEADBEEF, exp_q[i]);
        chk("mix_busy_end", busy, 0);

        // ---- reset with 3 reads outstanding ----
        for (int c = 0; c < 3; c++) begin
            @(posedge clock); #1; drive(1, 16'(c), 0, 16'h0, 32'h0, 0);
        end
        @(posedge clock); #1; idle(1'b0); reset = 1'b1;
        @(posedge clock); #1;
        @(negedge clock);
        chk("mrst_valid", ld_valid, 0);
        chk("mrst_busy", busy, 0);
        @(posedge clock); #1; reset = 1'b0;
        @(negedge clock);
        chk("mrst_rel_ld_stall", ld_stall, 1);
        chk("mrst_rel_st_stall", st_stall, 1);
        chk("mrst_rel_valid", ld_valid, 0);
        // four loads accepted without stall shows credits were restored
        exp_q = '{32'h11, 32'h55, 32'h12, 32'h13};
        for (int c = 0; c < 4; c++) begin
            @(posedge clock); #1;
            drive(1, (c == 0) ? 16'h1 : (c == 1) ? 16'h20 : 16'(c), 0, 16'h0, 32'h0, 0);
            @(negedge clock);
            chk($sformatf("mrst_ld%0d_stall", c), ld_stall, 0);
        end
        @(posedge clock); #1; idle(1'b0);
        @(negedge clock);
        chk("mrst_full_stall", ld_stall, 1);
        got.delete();
        for (int c = 0; c < 8; c++) begin
            @(posedge clock); #1; idle(1'b1);
            @(negedge clock);
            if (ld_valid) got.push_back(ld_data);
        end
        chk("mrst_count", got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            chk($sformatf("mrst_data%0d", i), (i < got.size()) ? got[i] : 32'hDEADBEEF, exp_q[i]);
        chk("mrst_busy_end", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
